// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helpers for the BCD-to-binary converter.
package bcd_pkg;

  localparam int              DIGIT_W        = 4;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_SUB    = 4'd3;
  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT  = 4'd9;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd2bin_state_t;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit correction used after each right shift of reverse double-dabble.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] q_o
);

  // A digit that received a '1' from the digit above now holds 8+x; subtracting 3 restores 5+x.
  assign q_o = (d_i >= BCD_ADJ_THRESH) ? (d_i - BCD_ADJ_SUB) : d_i;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential reverse double-dabble BCD to binary converter with start/done handshake.
// Optional macro BCD_TO_BIN_CHECK_EN rejects inputs containing digits above 9 (err=1, bin_out=0).
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [4*DIGITS-1:0]       dec_in,
  output logic                      busy,
  output logic                      done,
  output logic [BIN_W-1:0]          bin_out,
  output logic                      err
);

  localparam int NIB_W = DIGITS * DIGIT_W;
  localparam int SR_W  = 2 * NIB_W;
  localparam int CNT_W = (NIB_W > 1) ? $clog2(NIB_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NIB_W - 1);

  bcd2bin_state_t      state_q;
  logic [SR_W-1:0]     sr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [BIN_W-1:0]    bin_q;

  logic [SR_W-1:0]     sr_shift;
  logic [NIB_W-1:0]    digits_adj;
  logic [SR_W-1:0]     sr_d;

  // Upper half holds the BCD digits being consumed, lower half collects binary bits.
  assign sr_shift = sr_q >> 1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .d_i (sr_shift[NIB_W + gi*DIGIT_W +: DIGIT_W]),
        .q_o (digits_adj[gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  assign sr_d = {digits_adj, sr_shift[NIB_W-1:0]};

`ifdef BCD_TO_BIN_CHECK_EN
  logic                err_q;
  logic [DIGITS-1:0]   digit_bad;
  logic                dec_bad;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
      assign digit_bad[gi] = digit_invalid(dec_in[gi*DIGIT_W +: DIGIT_W]);
    end
  endgenerate

  assign dec_bad = |digit_bad;
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
`ifdef BCD_TO_BIN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
`ifdef BCD_TO_BIN_CHECK_EN
            if (dec_bad) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
              bin_q  <= '0;
            end else
`endif
            begin
              state_q <= SHIFT;
              sr_q    <= {dec_in, {NIB_W{1'b0}}};
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          sr_q <= sr_d;
          if (cnt_q == LAST_STEP) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bin_q   <= sr_d[BIN_W-1:0];
            cnt_q   <= '0;
`ifdef BCD_TO_BIN_CHECK_EN
            err_q   <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed, table-driven bench for bcd_to_bin with hand sequences for handshake corner cases.
module tb_bcd_to_bin;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] dec_in;
  logic        busy;
  logic        done;
  logic [11:0] bin_out;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;

  bcd_to_bin #(.DIGITS(3), .BIN_W(12)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dec_in  (dec_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] dec;
    int          exp_bin;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Launch one conversion, count busy cycles until done, then check result and pulse width.
  task automatic convert(input logic [11:0] dec, input int exp_bin, input string name);
    int busy_cycles;
    int n;
    bit seen;
    @(negedge clk);
    start  = 1'b1;
    dec_in = dec;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cycles = 0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
    check({name, " done_seen"}, int'(seen), 1);
    check({name, " busy_cycles"}, busy_cycles, 12);
    check({name, " bin_out"}, int'(bin_out), exp_bin);
    check({name, " err"}, int'(err), 0);
    @(negedge clk);
    check({name, " done_width"}, int'(done), 0);
    check({name, " bin_hold"}, int'(bin_out), exp_bin);
    $display("[TB] %s: dec_in=%h bin_out=%0d busy_cycles=%0d", name, dec, bin_out, busy_cycles);
  endtask

  initial begin
    int n, t1, t2, v1, v2, done_cnt, first_val;

    vecs[0] = '{12'h400, 400, "v400"};
    vecs[1] = '{12'h999, 999, "v999"};
    vecs[2] = '{12'h000,   0, "v000"};
    vecs[3] = '{12'h017,  17, "v017"};
    vecs[4] = '{12'h123, 123, "v123"};
    vecs[5] = '{12'h456, 456, "v456"};
    vecs[6] = '{12'h081,  81, "v081"};
    vecs[7] = '{12'h909, 909, "v909"};
    vecs[8] = '{12'h640, 640, "v640"};
    vecs[9] = '{12'h388, 388, "v388"};

    rst = 1'b1;
    start = 1'b0;
    dec_in = '0;
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset bin_out", int'(bin_out), 0);
    check("reset err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", int'(busy), 0);
    $display("[TB] reset: busy=%0d done=%0d bin_out=%0d err=%0d", busy, done, bin_out, err);

    for (int i = 0; i < 10; i++)
      convert(vecs[i].dec, vecs[i].exp_bin, vecs[i].name);

    // Start held high: zero-gap back-to-back, dec_in change mid-SHIFT ignored.
    @(negedge clk);
    start = 1'b1;
    dec_in = 12'h123;
    n = 0; t1 = -1; t2 = -1; v1 = -1; v2 = -1;
    while (n < 60 && t2 < 0) begin
      @(negedge clk);
      n++;
      if (n == 5) dec_in = 12'h456;
      if (done) begin
        if (t1 < 0) begin
          t1 = n;
          v1 = int'(bin_out);
        end else begin
          t2 = n;
          v2 = int'(bin_out);
          start = 1'b0;
        end
      end
    end
    check("b2b first latency", t1, 13);
    check("b2b first value", v1, 123);
    check("b2b spacing", t2 - t1, 13);
    check("b2b second value", v2, 456);
    @(negedge clk);
    check("b2b idle after", int'(busy), 0);
    $display("[TB] back-to-back: first=%0d@%0d second=%0d@%0d", v1, t1, v2, t2);

    // Start pulse while busy must be ignored.
    @(negedge clk);
    start = 1'b1;
    dec_in = 12'h250;
    done_cnt = 0;
    first_val = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) begin
        start = 1'b1;
        dec_in = 12'h777;
      end
      if (k == 6) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (first_val < 0) first_val = int'(bin_out);
      end
    end
    check("busy start done count", done_cnt, 1);
    check("busy start value", first_val, 250);
    $display("[TB] start-while-busy: done_count=%0d bin_out=%0d", done_cnt, first_val);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    start = 1'b1;
    dec_in = 12'h999;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre-abort busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort bin_out", int'(bin_out), 0);
    check("abort err", int'(err), 0);
    done_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort no done", done_cnt, 0);
    $display("[TB] async abort: busy=%0d bin_out=%0d late_done=%0d", busy, bin_out, done_cnt);
    convert(12'h640, 640, "post-abort");

    // Invalid digit handling.
    @(negedge clk);
    start = 1'b1;
    dec_in = 12'h4A0;
    @(posedge clk);
    #1 start = 1'b0;
`ifdef BCD_TO_BIN_CHECK_EN
    @(negedge clk);
    check("bad digit done", int'(done), 1);
    check("bad digit err", int'(err), 1);
    check("bad digit bin_out", int'(bin_out), 0);
    check("bad digit busy", int'(busy), 0);
    @(negedge clk);
    check("bad digit done width", int'(done), 0);
    $display("[TB] invalid 4A0: err=%0d bin_out=%0d", err, bin_out);
    convert(12'h017, 17, "after-bad");
`else
    n = 0;
    done_cnt = 0;
    while (n < 40 && done_cnt == 0) begin
      @(negedge clk);
      n++;
      if (done) begin
        done_cnt++;
        check("bad digit err tied", int'(err), 0);
      end
    end
    check("bad digit latency", n, 13);
    $display("[TB] invalid 4A0 unchecked: err=%0d latency=%0d", err, n);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
